// File: rtl/scu_dma_master_pkg.sv
// scu_dma_master_pkg: FSM states, CPU register indices and CTRL/STAT bit positions for the SCU DMA initiator
package scu_dma_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_WR_REQ = 2'd2
    } state_e;

    localparam int ADDR_W = 25;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_SRC_INC = 1;
    localparam int CTRL_DST_INC = 2;
    localparam int CTRL_ABORT   = 3;
    localparam int CTRL_IRQ_CLR = 8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_SRC_INC = 2;
    localparam int STAT_DST_INC = 3;
    localparam int STAT_IRQ     = 4;

endpackage

// File: rtl/scu_dma_master.sv
// scu_dma_master: block-copy DMA initiator on the SCU REQ/ACK word bus, one read then one write per word
//   CLK, RST_N (async, active-low), CE_R gates every state update, CE_F reserved
//   A/DI/DO/WR/RD   CPU register port: 0 SRC, 1 DST, 2 CNT, 3 CTRL (write) / STAT (read)
//   DMA_A/DMA_DO/DMA_DI/DMA_WR/DMA_REQ/DMA_ACK   bus initiator, request held until ACK
//   IRQ             level interrupt raised on completion, cleared by CTRL.IRQ_CLR
module scu_dma_master
    import scu_dma_master_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [1:0]  A,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    input  logic        WR,
    input  logic        RD,
    output logic [24:0] DMA_A,
    output logic [31:0] DMA_DO,
    input  logic [31:0] DMA_DI,
    output logic        DMA_WR,
    output logic        DMA_REQ,
    input  logic        DMA_ACK,
    output logic        IRQ
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
    logic              done_q, done_d, irq_q, irq_d;
    logic [31:0]       buf_q, buf_d, stat;
    logic              busy, ctrl_wr, abort, start;
    logic              unused;

    assign unused  = ^{CE_F, DI[31:27]};
    assign busy    = state_q != ST_IDLE;
    assign ctrl_wr = WR && A == REG_CTRL;
    assign abort   = ctrl_wr && DI[CTRL_ABORT];
    // ABORT in the same write as START takes priority
    assign start   = ctrl_wr && DI[CTRL_START] && !DI[CTRL_ABORT];

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        done_d    = done_q;
        irq_d     = irq_q;
        buf_d     = buf_q;
        // transfer parameters are frozen while a copy is running
        if (WR && !busy) begin
            if (A == REG_SRC) src_d = DI[ADDR_W+1:2];
            if (A == REG_DST) dst_d = DI[ADDR_W+1:2];
            if (A == REG_CNT) cnt_d = DI[CNT_W-1:0];
            if (A == REG_CTRL) begin
                src_inc_d = DI[CTRL_SRC_INC];
                dst_inc_d = DI[CTRL_DST_INC];
            end
        end
        // clear first so a completion on the same edge overrides it
        if (ctrl_wr && DI[CTRL_IRQ_CLR]) irq_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = cnt_q != '0 ? ST_RD_REQ : ST_IDLE;
                        done_d  = cnt_q == '0;
                        irq_d   = cnt_q == '0;
                    end
                end
                ST_RD_REQ: begin
                    if (DMA_ACK) begin
                        buf_d   = DMA_DI;
                        state_d = ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (DMA_ACK) begin
                        cnt_d = cnt_q != '0 ? cnt_q - CNT_W'(1) : '0;
                        src_d = src_q + ADDR_W'(src_inc_q);
                        dst_d = dst_q + ADDR_W'(dst_inc_q);
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = ST_RD_REQ;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            buf_q     <= '0;
        end else if (CE_R) begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
            buf_q     <= buf_d;
        end
    end

    always_comb begin
        stat               = '0;
        stat[STAT_BUSY]    = busy;
        stat[STAT_DONE]    = done_q;
        stat[STAT_SRC_INC] = src_inc_q;
        stat[STAT_DST_INC] = dst_inc_q;
        stat[STAT_IRQ]     = irq_q;
    end

    assign DO = !RD             ? 32'h0 :
                A == REG_SRC    ? {5'b0, src_q, 2'b0} :
                A == REG_DST    ? {5'b0, dst_q, 2'b0} :
                A == REG_CNT    ? 32'(cnt_q) : stat;

    assign DMA_REQ = busy;
    assign DMA_WR  = state_q == ST_WR_REQ;
    assign DMA_A   = state_q == ST_RD_REQ ? src_q : DMA_WR ? dst_q : '0;
    assign DMA_DO  = DMA_WR ? buf_q : '0;
    assign IRQ     = irq_q;

endmodule

// File: tb/tb_scu_dma_master.sv
// tb_scu_dma_master: directed checks of the SCU DMA initiator against a bench-side memory responder
module tb_scu_dma_master;

    logic        CLK, RST_N, CE_R, CE_F, WR, RD, DMA_WR, DMA_REQ, DMA_ACK, IRQ;
    logic [1:0]  A;
    logic [31:0] DI, DO, DMA_DO, DMA_DI;
    logic [24:0] DMA_A;

    int total = 0;
    int bad = 0;
    int delay = 0;
    int stop_after = 1000;
    int log_n = 0;
    int wcnt = 0;
    int n;
    logic        lw [64];
    logic [24:0] la [64];
    logic [31:0] ld [64];
    logic [31:0] mem [logic [24:0]];
    logic [24:0] ra;
    logic        rw;
    logic [31:0] rdo;

    scu_dma_master dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .DI(DI), .DO(DO),
        .WR(WR), .RD(RD), .DMA_A(DMA_A), .DMA_DO(DMA_DO), .DMA_DI(DMA_DI),
        .DMA_WR(DMA_WR), .DMA_REQ(DMA_REQ), .DMA_ACK(DMA_ACK), .IRQ(IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge CLK);
        A = a;
        DI = d;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        A = a;
        RD = 1'b1;
        #1;
        d = DO;
        RD = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        while (DMA_REQ && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
        chk("idle_timeout", 32'(DMA_REQ), 0);
    endtask

    task automatic chk_bus(input int i, input logic w, input logic [24:0] a, input logic [31:0] d);
        chk($sformatf("bus%0d_wr", i), 32'(lw[i]), 32'(w));
        chk($sformatf("bus%0d_a", i), 32'(la[i]), 32'(a));
        chk($sformatf("bus%0d_d", i), ld[i], d);
    endtask

    // zero-wait-capable responder: ACK after 'delay' idle cycles, stalls once stop_after beats logged
    always @(negedge CLK) begin
        DMA_ACK = 1'b0;
        if (RST_N && DMA_REQ && log_n < stop_after) begin
            if (wcnt == 0) begin
                ra = DMA_A;
                rw = DMA_WR;
                rdo = DMA_DO;
            end else begin
                chk("hold_a", 32'(DMA_A), 32'(ra));
                chk("hold_wr", 32'(DMA_WR), 32'(rw));
                chk("hold_do", DMA_DO, rdo);
            end
            if (wcnt == delay) begin
                DMA_ACK = 1'b1;
                wcnt = 0;
                if (DMA_WR) mem[DMA_A] = DMA_DO;
                else DMA_DI = mem.exists(DMA_A) ? mem[DMA_A] : 32'h0;
                if (log_n < 64) begin
                    lw[log_n] = DMA_WR;
                    la[log_n] = DMA_A;
                    ld[log_n] = DMA_WR ? DMA_DO : DMA_DI;
                end
                log_n++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    initial begin
        RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b0; A = 2'd0; DI = 32'h0; WR = 1'b0; RD = 1'b0;
        DMA_ACK = 1'b0; DMA_DI = 32'h0;
        mem[25'h10] = 32'hA5A50010;
        mem[25'h11] = 32'h12345678;
        mem[25'h12] = 32'hDEADBEEF;
        mem[25'h0] = 32'h0;
        mem[25'h1FFFFFF] = 32'h0;
        #2;
        chk("rst_req", 32'(DMA_REQ), 0);
        chk("rst_irq", 32'(IRQ), 0);
        chk("rst_dma_a", 32'(DMA_A), 0);
        chk("rst_dma_do", DMA_DO, 0);
        rd_chk("rst_stat", 2'd3, 32'h0);
        rd_chk("rst_src", 2'd0, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        CE_R = 1'b0;
        cpu_wr(2'd0, 32'h100);
        rd_chk("ce_gate_src", 2'd0, 32'h0);
        CE_R = 1'b1;

        log_n = 0;
        cpu_wr(2'd0, 32'h40);
        cpu_wr(2'd1, 32'h100);
        cpu_wr(2'd2, 32'd3);
        cpu_wr(2'd3, 32'h7);
        chk("t1_busy", 32'(DMA_REQ), 1);
        wait_idle(100, n);
        chk("t1_cycles", 32'(n), 6);
        chk("t1_beats", 32'(log_n), 6);
        chk_bus(0, 1'b0, 25'h10, 32'hA5A50010);
        chk_bus(1, 1'b1, 25'h40, 32'hA5A50010);
        chk_bus(2, 1'b0, 25'h11, 32'h12345678);
        chk_bus(3, 1'b1, 25'h41, 32'h12345678);
        chk_bus(4, 1'b0, 25'h12, 32'hDEADBEEF);
        chk_bus(5, 1'b1, 25'h42, 32'hDEADBEEF);
        chk("t1_irq", 32'(IRQ), 1);
        rd_chk("t1_stat", 2'd3, 32'h1E);
        rd_chk("t1_src", 2'd0, 32'h4C);
        rd_chk("t1_dst", 2'd1, 32'h10C);
        rd_chk("t1_cnt", 2'd2, 32'h0);
        A = 2'd3;
        RD = 1'b0;
        #1;
        chk("do_no_rd", DO, 0);

        cpu_wr(2'd3, 32'h100);
        chk("clr_irq", 32'(IRQ), 0);
        rd_chk("clr_stat", 2'd3, 32'h02);
        cpu_wr(2'd2, 32'd0);
        log_n = 0;
        cpu_wr(2'd3, 32'h1);
        chk("z_irq", 32'(IRQ), 1);
        rd_chk("z_stat", 2'd3, 32'h12);
        repeat (3) @(negedge CLK);
        chk("z_req", 32'(DMA_REQ), 0);
        chk("z_beats", 32'(log_n), 0);
        cpu_wr(2'd3, 32'h100);
        chk("z_clr_irq", 32'(IRQ), 0);
        rd_chk("z_clr_stat", 2'd3, 32'h02);

        log_n = 0;
        cpu_wr(2'd0, 32'h40);
        cpu_wr(2'd1, 32'h07FFFFFC);
        cpu_wr(2'd2, 32'd2);
        cpu_wr(2'd3, 32'h5);
        wait_idle(100, n);
        chk("w_cycles", 32'(n), 4);
        chk("w_beats", 32'(log_n), 4);
        chk_bus(0, 1'b0, 25'h10, 32'hA5A50010);
        chk_bus(1, 1'b1, 25'h1FFFFFF, 32'hA5A50010);
        chk_bus(2, 1'b0, 25'h10, 32'hA5A50010);
        chk_bus(3, 1'b1, 25'h0, 32'hA5A50010);
        chk("w_mem0", mem[25'h0], 32'hA5A50010);
        rd_chk("w_dst", 2'd1, 32'h4);
        rd_chk("w_src", 2'd0, 32'h40);
        rd_chk("w_stat", 2'd3, 32'h1A);

        log_n = 0;
        delay = 5;
        cpu_wr(2'd0, 32'h40);
        cpu_wr(2'd1, 32'h140);
        cpu_wr(2'd2, 32'd3);
        cpu_wr(2'd3, 32'h7);
        wait_idle(300, n);
        chk("d_cycles", 32'(n), 36);
        chk("d_beats", 32'(log_n), 6);
        chk_bus(1, 1'b1, 25'h50, 32'hA5A50010);
        chk_bus(4, 1'b0, 25'h12, 32'hDEADBEEF);
        chk_bus(5, 1'b1, 25'h52, 32'hDEADBEEF);
        chk("d_mem51", mem[25'h51], 32'h12345678);
        chk("d_irq", 32'(IRQ), 1);
        rd_chk("d_stat", 2'd3, 32'h1E);
        delay = 0;

        log_n = 0;
        stop_after = 2;
        cpu_wr(2'd0, 32'h40);
        cpu_wr(2'd1, 32'h180);
        cpu_wr(2'd2, 32'd4);
        cpu_wr(2'd3, 32'h7);
        repeat (6) @(negedge CLK);
        chk("a_req", 32'(DMA_REQ), 1);
        chk("a_wr", 32'(DMA_WR), 0);
        chk("a_addr", 32'(DMA_A), 32'h11);
        chk("a_mem60", mem[25'h60], 32'hA5A50010);
        cpu_wr(2'd3, 32'h8);
        chk("a_req_drop", 32'(DMA_REQ), 0);
        chk("a_irq", 32'(IRQ), 0);
        rd_chk("a_stat", 2'd3, 32'h0C);
        rd_chk("a_cnt", 2'd2, 32'd3);
        rd_chk("a_src", 2'd0, 32'h44);
        rd_chk("a_dst", 2'd1, 32'h184);
        stop_after = 1000;
        repeat (3) @(negedge CLK);
        chk("a_quiet", 32'(DMA_REQ), 0);
        chk("a_beats", 32'(log_n), 2);

        log_n = 0;
        stop_after = 1;
        cpu_wr(2'd0, 32'h40);
        cpu_wr(2'd1, 32'h1C0);
        cpu_wr(2'd2, 32'd2);
        cpu_wr(2'd3, 32'h7);
        repeat (4) @(negedge CLK);
        chk("r_req", 32'(DMA_REQ), 1);
        chk("r_wr", 32'(DMA_WR), 1);
        chk("r_addr", 32'(DMA_A), 32'h70);
        chk("r_do", DMA_DO, 32'hA5A50010);
        cpu_wr(2'd0, 32'h800);
        rd_chk("r_src_busy", 2'd0, 32'h40);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("r_req0", 32'(DMA_REQ), 0);
        chk("r_wr0", 32'(DMA_WR), 0);
        chk("r_a0", 32'(DMA_A), 0);
        chk("r_do0", DMA_DO, 0);
        chk("r_irq0", 32'(IRQ), 0);
        rd_chk("r_src0", 2'd0, 32'h0);
        rd_chk("r_dst0", 2'd1, 32'h0);
        rd_chk("r_cnt0", 2'd2, 32'h0);
        rd_chk("r_stat0", 2'd3, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        stop_after = 1000;
        repeat (2) @(negedge CLK);
        chk("r_after", 32'(DMA_REQ), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
